c_dcache: RTL

// - Data cache responder for the C (memory) stage: serves word loads/stores issued by C, refills from the memory bus.
// - Direct-mapped, write-through, no-write-allocate, blocking (one request in flight).
// - Sits between C stage (initiator) and external data memory bus; C stalls while req_ready=0.

---
 rtl/c_dcache_pkg.sv | 24 ++
 rtl/c_dcache_data.sv | 32 +++
 rtl/c_dcache.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/c_dcache_pkg.sv
// Shared definitions for the C-stage data cache: default geometry, FSM state
// encoding and small arithmetic helpers.
package c_dcache_pkg;

    localparam int DEF_LINES  = 16;
    localparam int DEF_WPL    = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_COMPARE     = 3'd1,
        S_REFILL_REQ  = 3'd2,
        S_REFILL_WAIT = 3'd3,
        S_WRITE_REQ   = 3'd4,
        S_WRITE_WAIT  = 3'd5
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/c_dcache_data.sv
// Data store for the cache: one word per entry, combinational read port and a
// byte-enabled synchronous write port.
module c_dcache_data
    import c_dcache_pkg::*;
#(
    parameter int DEPTH = DEF_LINES * DEF_WPL,
    parameter int AW    = $clog2(DEF_LINES * DEF_WPL)
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/c_dcache.sv
// Direct-mapped, write-through, no-write-allocate blocking data cache for the
// C stage. Tags, valid bits and the control FSM live here; words live in c_dcache_data.
module c_dcache
    import c_dcache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WPL,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_load,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output state_t            dbg_state
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W - 2;
    localparam int IDX_LO = 2 + OFF_W;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam int DA_W   = IDX_W + OFF_W;

    // Handshakes: a transfer happens on a posedge where valid && ready; the
    // initiator holds valid and payload stable until that edge.

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:2]   r_word_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_is_load;
    logic                r_is_store;
    logic [OFF_W-1:0]    r_cnt;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag [LINES];
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic [OFF_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_last;
    logic                w_is_mem_op;
    logic [DATA_W-1:0]   w_rd_data;
    logic [DATA_W-1:0]   w_refill_word;
    logic                w_dwe;
    logic [DA_W-1:0]     w_dwaddr;
    logic [DATA_W-1:0]   w_dwdata;
    logic [STRB_W-1:0]   w_dwstrb;
    logic                w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = &{1'b0, req_addr[1:0]};

    assign w_off       = r_word_addr[IDX_LO-1:2];
    assign w_idx       = r_word_addr[TAG_LO-1:IDX_LO];
    assign w_tag       = r_word_addr[ADDR_W-1:TAG_LO];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last      = (r_cnt == OFF_W'(WORDS_PER_LINE - 1));
    assign w_is_mem_op = r_is_load | r_is_store;

    // On the last refill beat the requested word may still be on the bus.
    assign w_refill_word = (w_off == r_cnt) ? mem_rdata : w_rd_data;

    c_dcache_data #(
        .DEPTH (LINES * WORDS_PER_LINE),
        .AW    (DA_W)
    ) u_data (
        .clock   (clock),
        .i_we    (w_dwe),
        .i_waddr (w_dwaddr),
        .i_wdata (w_dwdata),
        .i_wstrb (w_dwstrb),
        .i_raddr ({w_idx, w_off}),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_next_state  = r_state;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        w_dwe         = 1'b0;
        w_dwaddr      = '0;
        w_dwdata      = '0;
        w_dwstrb      = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_next_state = S_COMPARE;
            end
            S_COMPARE: begin
                if (r_is_store) begin
                    w_dwe        = w_hit;
                    w_dwaddr     = {w_idx, w_off};
                    w_dwdata     = r_wdata;
                    w_dwstrb     = r_wstrb;
                    w_next_state = S_WRITE_REQ;
                end else if (r_is_load && !w_hit) begin
                    w_next_state = S_REFILL_REQ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = {w_tag, w_idx, r_cnt, 2'b00};
                if (mem_req_ready) w_next_state = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    w_dwe        = 1'b1;
                    w_dwaddr     = {w_idx, r_cnt};
                    w_dwdata     = mem_rdata;
                    w_dwstrb     = '1;
                    w_next_state = w_last ? S_IDLE : S_REFILL_REQ;
                end
            end
            S_WRITE_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_addr      = {r_word_addr, 2'b00};
                mem_wdata     = r_wdata;
                mem_wstrb     = r_wstrb;
                if (mem_req_ready) w_next_state = S_WRITE_WAIT;
            end
            S_WRITE_WAIT: begin
                if (mem_resp_valid) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_word_addr  <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_cnt        <= '0;
            r_valid      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_word_addr <= req_addr[ADDR_W-1:2];
                        r_wdata     <= req_wdata;
                        r_wstrb     <= req_wstrb;
                        r_is_store  <= req_is_store;
                        r_is_load   <= req_is_load & ~req_is_store;
                    end
                end
                S_COMPARE: begin
                    if (w_is_mem_op) begin
                        if (w_hit) r_hit_count  <= sat_inc(r_hit_count);
                        else       r_miss_count <= sat_inc(r_miss_count);
                    end
                    if (r_is_load) begin
                        if (w_hit) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_rd_data;
                        end else begin
                            r_valid[w_idx] <= 1'b0;
                            r_cnt          <= '0;
                        end
                    end else if (!r_is_store) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                    end
                end
                S_REFILL_WAIT: begin
                    if (mem_resp_valid) begin
                        if (w_last) begin
                            r_valid[w_idx] <= 1'b1;
                            r_resp_valid   <= 1'b1;
                            r_resp_rdata   <= w_refill_word;
                        end else begin
                            r_cnt <= r_cnt + OFF_W'(1);
                        end
                    end
                end
                S_WRITE_WAIT: begin
                    if (mem_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clock) begin
        if (r_state == S_REFILL_WAIT && mem_resp_valid && w_last) begin
            r_tag[w_idx] <= w_tag;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
    assign dbg_state  = r_state;

endmodule
